// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: decode/execute hazard inputs and PC/buffer control outputs
// shared between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_if #(parameter int REG_W = 6);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_valid;
    logic [REG_W-1:0] ex_rd;
    logic             ex_MemRead;
    logic             ex_RegWrite;
    logic             ex_redirect;
    logic [31:0]      ex_target;
    logic             pc_we;
    logic             pc_sel;
    logic [31:0]      pc_target;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_valid, ex_rd, ex_MemRead, ex_RegWrite, ex_redirect, ex_target,
        input  pc_we, pc_sel, pc_target, ifid_we, ifid_flush, idex_bubble
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_valid, ex_rd, ex_MemRead, ex_RegWrite, ex_redirect, ex_target,
        output pc_we, pc_sel, pc_target, ifid_we, ifid_flush, idex_bubble
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall and EX-redirect flush control for the
// three-buffer pipeline, with saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 6,
    parameter int LOAD_STALL  = 1,
    parameter int EXTRA_FLUSH = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_if.slave     hif,
    input  logic             cnt_clr,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [1:0] RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2;

    logic [1:0] next_state;
    logic [1:0] cnt, next_cnt;
    logic       hz, rd, stall, flush;

    assign hz = hif.id_valid & hif.ex_valid & hif.ex_MemRead & hif.ex_RegWrite &
                (hif.ex_rd != REG_W'(0)) &
                ((hif.id_uses_rs & (hif.id_rs == hif.ex_rd)) |
                 (hif.id_uses_rt & (hif.id_rt == hif.ex_rd)));
    assign rd = hif.ex_valid & hif.ex_redirect;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end

    // Redirect beats everything; STALL/FLUSH count down and ignore new hazards.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (rd) begin
            next_state = EXTRA_FLUSH > 0 ? FLUSH : RUN;
            next_cnt   = 2'(EXTRA_FLUSH);
        end else if (state == STALL || state == FLUSH) begin
            next_state = cnt == 2'd1 ? RUN : state;
            next_cnt   = cnt - 2'd1;
        end else if (state == RUN && hz) begin
            next_state = LOAD_STALL > 1 ? STALL : RUN;
            next_cnt   = 2'(LOAD_STALL - 1);
        end else begin
            next_state = RUN;
            next_cnt   = 2'd0;
        end
    end

    always_comb begin
        stall           = !rd && (state == STALL || (state == RUN && hz));
        flush           = !rd && state == FLUSH;
        hif.pc_we       = rst_n & !stall;
        hif.ifid_we     = rst_n & !stall;
        hif.pc_sel      = rst_n & rd;
        hif.ifid_flush  = !rst_n | rd | flush;
        hif.idex_bubble = !rst_n | rd | stall;
        hif.pc_target   = hif.ex_target;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (rd && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of two controller configurations
// (LOAD_STALL=1/EXTRA_FLUSH=1/CNT_W=2 and LOAD_STALL=3/EXTRA_FLUSH=0/CNT_W=16).
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic clr_a, clr_b;
    logic [1:0]  state_a, state_b;
    logic [1:0]  stall_a, flush_a;
    logic [15:0] stall_b, flush_b;
    int errors = 0;
    int checks = 0;

    pipe_hazard_if #(.REG_W(6)) ia();
    pipe_hazard_if #(.REG_W(6)) ib();

    pipe_hazard_ctrl #(.REG_W(6), .LOAD_STALL(1), .EXTRA_FLUSH(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .hif(ia), .cnt_clr(clr_a),
        .state(state_a), .stall_cnt(stall_a), .flush_cnt(flush_a));
    pipe_hazard_ctrl #(.REG_W(6), .LOAD_STALL(3), .EXTRA_FLUSH(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .hif(ib), .cnt_clr(clr_b),
        .state(state_b), .stall_cnt(stall_b), .flush_cnt(flush_b));

    always #5 clk = ~clk;

    // {pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble}
    wire [4:0] ctl_a = {ia.pc_we, ia.pc_sel, ia.ifid_we, ia.ifid_flush, ia.idex_bubble};
    wire [4:0] ctl_b = {ib.pc_we, ib.pc_sel, ib.ifid_we, ib.ifid_flush, ib.idex_bubble};
    localparam logic [4:0] C_RUN = 5'b10100, C_STALL = 5'b00001, C_REDIR = 5'b11111,
                           C_FLUSH = 5'b10110, C_RST = 5'b00011;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a;
        ia.id_valid = 1'b0; ia.id_rs = 6'd0; ia.id_rt = 6'd0; ia.id_uses_rs = 1'b0;
        ia.id_uses_rt = 1'b0; ia.ex_valid = 1'b0; ia.ex_rd = 6'd0; ia.ex_MemRead = 1'b0;
        ia.ex_RegWrite = 1'b0; ia.ex_redirect = 1'b0; ia.ex_target = 32'h0;
    endtask

    task automatic idle_b;
        ib.id_valid = 1'b0; ib.id_rs = 6'd0; ib.id_rt = 6'd0; ib.id_uses_rs = 1'b0;
        ib.id_uses_rt = 1'b0; ib.ex_valid = 1'b0; ib.ex_rd = 6'd0; ib.ex_MemRead = 1'b0;
        ib.ex_RegWrite = 1'b0; ib.ex_redirect = 1'b0; ib.ex_target = 32'h0;
    endtask

    // LW r5 in EX, ADD r6,r5,r7 in ID
    task automatic lu_a;
        idle_a;
        ia.id_valid = 1'b1; ia.id_rs = 6'd5; ia.id_rt = 6'd7; ia.id_uses_rs = 1'b1;
        ia.id_uses_rt = 1'b1; ia.ex_valid = 1'b1; ia.ex_rd = 6'd5; ia.ex_MemRead = 1'b1;
        ia.ex_RegWrite = 1'b1;
    endtask

    task automatic lu_b;
        idle_b;
        ib.id_valid = 1'b1; ib.id_rs = 6'd5; ib.id_rt = 6'd7; ib.id_uses_rs = 1'b1;
        ib.id_uses_rt = 1'b1; ib.ex_valid = 1'b1; ib.ex_rd = 6'd5; ib.ex_MemRead = 1'b1;
        ib.ex_RegWrite = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        lu_a; ia.ex_redirect = 1'b1;
        lu_b;
        #2;
        checks++; if (ctl_a !== C_RST) begin errors++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, C_RST); end
        checks++; if (ctl_b !== C_RST) begin errors++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, C_RST); end
        checks++; if ({state_a, stall_a, flush_a} !== 6'd0) begin errors++; $display("FAIL reset_state_a got=%0d/%0d/%0d exp=0/0/0", state_a, stall_a, flush_a); end
        checks++; if ({state_b, stall_b, flush_b} !== 34'd0) begin errors++; $display("FAIL reset_state_b got=%0d/%0d/%0d exp=0/0/0", state_b, stall_b, flush_b); end
        step; step;
        idle_a; idle_b;
        rst_n = 1'b1;
        #1;
        checks++; if (ctl_a !== C_RUN) begin errors++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl_a, C_RUN); end
        step;
    endtask

    task automatic test_no_stall;
        idle_a;
        ia.id_valid = 1'b1; ia.id_uses_rs = 1'b1; ia.ex_valid = 1'b1;
        ia.ex_MemRead = 1'b1; ia.ex_RegWrite = 1'b1;
        #1;
        checks++; if (ctl_a !== C_RUN) begin errors++; $display("FAIL nostall_r0 got=%b exp=%b", ctl_a, C_RUN); end
        step;
        lu_a; ia.id_uses_rs = 1'b0;
        #1;
        checks++; if (ctl_a !== C_RUN) begin errors++; $display("FAIL nostall_unused_rs got=%b exp=%b", ctl_a, C_RUN); end
        step;
        checks++; if (stall_a !== 2'd0) begin errors++; $display("FAIL nostall_cnt got=%0d exp=0", stall_a); end
    endtask

    task automatic test_load_use_1;
        lu_a;
        #1;
        checks++; if (ctl_a !== C_STALL || state_a !== 2'd0) begin errors++; $display("FAIL lu1_stall got=%b st=%0d exp=%b st=0", ctl_a, state_a, C_STALL); end
        step;
        idle_a; ia.ex_valid = 1'b1; ia.ex_rd = 6'd6; ia.ex_RegWrite = 1'b1;
        #1;
        checks++; if (ctl_a !== C_RUN || state_a !== 2'd0) begin errors++; $display("FAIL lu1_resume got=%b st=%0d exp=%b st=0", ctl_a, state_a, C_RUN); end
        checks++; if (stall_a !== 2'd1) begin errors++; $display("FAIL lu1_cnt got=%0d exp=1", stall_a); end
        step;
    endtask

    task automatic test_load_use_3;
        lu_b;
        #1;
        checks++; if (ctl_b !== C_STALL || state_b !== 2'd0) begin errors++; $display("FAIL lu3_detect got=%b st=%0d exp=%b st=0", ctl_b, state_b, C_STALL); end
        step;
        for (int i = 0; i < 2; i++) begin
            lu_b; ib.ex_valid = 1'b0;
            #1;
            checks++; if (ctl_b !== C_STALL || state_b !== 2'd1) begin errors++; $display("FAIL lu3_hold%0d got=%b st=%0d exp=%b st=1", i, ctl_b, state_b, C_STALL); end
            step;
        end
        idle_b; ib.ex_valid = 1'b1; ib.ex_rd = 6'd6; ib.ex_RegWrite = 1'b1;
        #1;
        checks++; if (ctl_b !== C_RUN || state_b !== 2'd0) begin errors++; $display("FAIL lu3_resume got=%b st=%0d exp=%b st=0", ctl_b, state_b, C_RUN); end
        checks++; if (stall_b !== 16'd3) begin errors++; $display("FAIL lu3_cnt got=%0d exp=3", stall_b); end
        step;
        idle_b; ib.ex_valid = 1'b1; ib.ex_redirect = 1'b1; ib.ex_target = 32'h80;
        #1;
        checks++; if (ctl_b !== C_REDIR) begin errors++; $display("FAIL b_redirect got=%b exp=%b", ctl_b, C_REDIR); end
        step;
        idle_b;
        #1;
        checks++; if (ctl_b !== C_RUN || state_b !== 2'd0 || flush_b !== 16'd1) begin errors++; $display("FAIL b_noextra got=%b st=%0d fc=%0d exp=%b st=0 fc=1", ctl_b, state_b, flush_b, C_RUN); end
        step;
    endtask

    task automatic test_redirect;
        lu_a; ia.ex_redirect = 1'b1; ia.ex_target = 32'h40;
        #1;
        checks++; if (ctl_a !== C_REDIR) begin errors++; $display("FAIL redir_ctl got=%b exp=%b", ctl_a, C_REDIR); end
        checks++; if (ia.pc_target !== 32'h40) begin errors++; $display("FAIL redir_target got=%h exp=40", ia.pc_target); end
        step;
        lu_a;
        #1;
        checks++; if (ctl_a !== C_FLUSH || state_a !== 2'd2) begin errors++; $display("FAIL redir_flush got=%b st=%0d exp=%b st=2", ctl_a, state_a, C_FLUSH); end
        checks++; if (flush_a !== 2'd1 || stall_a !== 2'd1) begin errors++; $display("FAIL redir_cnts got=%0d/%0d exp=1/1", flush_a, stall_a); end
        step;
        idle_a;
        #1;
        checks++; if (ctl_a !== C_RUN || state_a !== 2'd0) begin errors++; $display("FAIL redir_done got=%b st=%0d exp=%b st=0", ctl_a, state_a, C_RUN); end
        step;
    endtask

    task automatic test_back_to_back;
        idle_a; ia.ex_valid = 1'b1; ia.ex_redirect = 1'b1;
        #1;
        checks++; if (ctl_a !== C_REDIR) begin errors++; $display("FAIL b2b_first got=%b exp=%b", ctl_a, C_REDIR); end
        step;
        #1;
        checks++; if (ctl_a !== C_REDIR || state_a !== 2'd2) begin errors++; $display("FAIL b2b_second got=%b st=%0d exp=%b st=2", ctl_a, state_a, C_REDIR); end
        step;
        idle_a;
        #1;
        checks++; if (ctl_a !== C_FLUSH || state_a !== 2'd2 || flush_a !== 2'd3) begin errors++; $display("FAIL b2b_reload got=%b st=%0d fc=%0d exp=%b st=2 fc=3", ctl_a, state_a, flush_a, C_FLUSH); end
        step;
        #1;
        checks++; if (ctl_a !== C_RUN || state_a !== 2'd0) begin errors++; $display("FAIL b2b_done got=%b st=%0d exp=%b st=0", ctl_a, state_a, C_RUN); end
    endtask

    task automatic test_saturation;
        int exp_s;
        exp_s = 1;
        for (int i = 0; i < 5; i++) begin
            lu_a;
            #1;
            checks++; if (ctl_a !== C_STALL) begin errors++; $display("FAIL sat_stall%0d got=%b exp=%b", i, ctl_a, C_STALL); end
            step;
            exp_s = exp_s < 3 ? exp_s + 1 : 3;
            checks++; if (stall_a !== 2'(exp_s)) begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, stall_a, exp_s); end
        end
        lu_a; clr_a = 1'b1;
        #1;
        checks++; if (ctl_a !== C_STALL) begin errors++; $display("FAIL clr_stall got=%b exp=%b", ctl_a, C_STALL); end
        step;
        clr_a = 1'b0;
        checks++; if (stall_a !== 2'd0 || flush_a !== 2'd0) begin errors++; $display("FAIL clr_cnts got=%0d/%0d exp=0/0", stall_a, flush_a); end
    endtask

    task automatic test_reset_mid_flush;
        idle_a; ia.ex_valid = 1'b1; ia.ex_redirect = 1'b1;
        #1;
        step;
        idle_a;
        #1;
        checks++; if (state_a !== 2'd2 || flush_a !== 2'd1) begin errors++; $display("FAIL rmf_inflush st=%0d fc=%0d exp st=2 fc=1", state_a, flush_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (ctl_a !== C_RST || state_a !== 2'd0 || flush_a !== 2'd0) begin errors++; $display("FAIL rmf_abort got=%b st=%0d fc=%0d exp=%b st=0 fc=0", ctl_a, state_a, flush_a, C_RST); end
        step;
        rst_n = 1'b1;
        #1;
        checks++; if (ctl_a !== C_RUN || state_a !== 2'd0 || {stall_a, flush_a} !== 4'd0 || stall_b !== 16'd0) begin errors++; $display("FAIL rmf_release got=%b st=%0d sc=%0d fc=%0d exp=%b st=0 sc=0 fc=0", ctl_a, state_a, stall_a, flush_a, C_RUN); end
        step;
        checks++; if (state_a !== 2'd0) begin errors++; $display("FAIL rmf_run st=%0d exp=0", state_a); end
    endtask

    initial begin
        test_reset;
        test_no_stall;
        test_load_use_1;
        test_load_use_3;
        test_redirect;
        test_back_to_back;
        test_saturation;
        test_reset_mid_flush;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the three-buffer pipelined CPU (IF/ID, ID/EX, EX/MEM/WB). It detects load-use hazards between the instruction in decode and the instruction in execute, and redirects the PC on branches or jumps resolved in EX. It drives the write-enable and flush/bubble controls of the PC, the IF/ID buffer and the ID/EX buffer, and keeps saturating stall and flush event counters.

## Interface
- REG_W, 6, register-number width; matches the rd field of the pipeline buffers.
- LOAD_STALL, 1, bubble cycles per load-use hazard; legal range 1..3.
- EXTRA_FLUSH, 1, additional IF/ID flush cycles after a redirect, covering synchronous instruction-memory latency; legal range 0..3.
- CNT_W, 16, width of each event counter.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs, id_rt  in  REG_W  source register numbers in decode.
- id_uses_rs, id_uses_rt  in  1  decode instruction actually reads rs / rt.
- ex_valid  in  1  execute stage holds a real instruction.
- ex_rd  in  REG_W  destination register in execute.
- ex_MemRead, ex_RegWrite  in  1  control bits from the ID/EX buffer.
- ex_redirect  in  1  taken BrZ/BrN, jump or jump_mem resolved in EX this cycle.
- ex_target  in  32  redirect target PC.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_we  out  1  PC register load enable.
- pc_sel  out  1  1 = load pc_target, 0 = load PC+1.
- pc_target  out  32  equals ex_target.
- ifid_we  out  1  IF/ID buffer load enable; 0 holds the buffer.
- ifid_flush  out  1  IF/ID loads a NOP (instr = 0) at the next edge.
- idex_bubble  out  1  ID/EX control fields load 0 at the next edge.
- state  out  2  current state: 0 RUN, 1 STALL, 2 FLUSH.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

## Operation
- Load-use hazard: hz = id_valid & ex_valid & ex_MemRead & ex_RegWrite & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)). Register 0 never causes a hazard.
- Redirect: rd = ex_valid & ex_redirect. A redirect has absolute priority over hz in every state.
- Stall outputs: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, pc_sel=0.
- Redirect outputs: pc_we=1, pc_sel=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
- Flush outputs: pc_we=1, pc_sel=0, ifid_we=1, ifid_flush=1, idex_bubble=0.
- Default (RUN) outputs: pc_we=1, ifid_we=1, everything else 0.
- RUN:
  - On rd: drive redirect outputs. Go to FLUSH with cnt=EXTRA_FLUSH if EXTRA_FLUSH>0; otherwise stay in RUN.
  - Else on hz: drive stall outputs. Go to STALL with cnt=LOAD_STALL-1 if LOAD_STALL>1; otherwise stay in RUN.
- STALL:
  - On rd: redirect behaviour, as in RUN.
  - Otherwise: drive stall outputs and decrement cnt. When cnt==1, return to RUN.
- FLUSH:
  - On rd: redirect outputs; cnt reloads to EXTRA_FLUSH and the state remains FLUSH.
  - Otherwise: drive flush outputs and decrement cnt. When cnt==1, return to RUN.
  - hz is ignored in FLUSH, because the decode stage holds a flushed NOP.
- Counters:
  - stall_cnt increments on every cycle that drives stall outputs.
  - flush_cnt increments once per redirect cycle.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr forces both to 0 and wins over an increment in the same cycle.

## Timing
- Control outputs are combinational from the inputs and the registered state, with zero-cycle latency, so the buffers sample them at the same edge that would advance the pipeline.
- A load-use hazard costs exactly LOAD_STALL cycles. A redirect costs 2 + EXTRA_FLUSH squashed fetch slots.
- While rst_n=0, regardless of the inputs:
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pc_sel=0.
  - state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
- Reset assertion mid-STALL or mid-FLUSH aborts the sequence immediately (asynchronous). The first cycle after release is RUN.
- Counter values update at the rising edge after the triggering cycle.

## Test plan
- LW r5 then ADD r6,r5,r7 (LOAD_STALL=1):
  - Exactly one cycle with pc_we=0, ifid_we=0, idex_bubble=1.
  - stall_cnt goes 0→1.
  - The ADD reaches EX one cycle late.
- Same sequence with LOAD_STALL=3:
  - state reads 1 for two cycles after detection.
  - Three bubble cycles in total; stall_cnt=3.
- Taken BrZ in EX, ex_target=0x40, EXTRA_FLUSH=1:
  - Redirect cycle has pc_sel=1, ifid_flush=1, idex_bubble=1.
  - The following cycle has ifid_flush=1, idex_bubble=0.
  - Then RUN; the PC loads 0x40; flush_cnt=1.
- LW r0 followed by a read of r0; also LW r5 followed by an instruction with id_uses_rs=0 and id_rs=5:
  - No stall in either case; stall_cnt stays 0.
- CNT_W=2, five back-to-back load-use hazards:
  - stall_cnt saturates at 3.
  - cnt_clr pulsed together with a sixth hazard leaves stall_cnt=0.
- rst_n dropped during the FLUSH cycle:
  - Outputs immediately show pc_we=0, ifid_flush=1, idex_bubble=1.
  - After release, state=0 and counters are 0.
